// File: rtl/acumulador_accumulator_slave_if.sv
// Single-register Avalon-MM slave bus for the accumulator: write strobe/data in, read strobe in, readdata out.
interface acumulador_accumulator_slave_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  write;
  logic [DATA_WIDTH-1:0] writedata;
  logic                  read;
  logic [DATA_WIDTH-1:0] readdata;

  modport master (output write, output writedata, output read, input readdata);
  modport slave  (input write, input writedata, input read, output readdata);
endinterface

// File: rtl/acumulador_accumulator_slave.sv
// Avalon-MM accumulator: every accepted write adds writedata to a running sum,
// readable with zero latency and exported continuously on a conduit.
module acumulador_accumulator_slave #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  acumulador_accumulator_slave_if.slave avs,
  output logic [DATA_WIDTH-1:0] sum_export
);

  logic [DATA_WIDTH-1:0] sum;

  // Modulo-2^N add; carry-out is intentionally dropped.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)       sum <= '0;
    else if (avs.write) sum <= sum + avs.writedata;
  end

  // Read returns the pre-edge sum, so a same-cycle write shows up only after the edge.
  assign avs.readdata = avs.read ? sum : '0;
  assign sum_export   = sum;

endmodule

// File: tb/tb_acumulador_accumulator_slave.sv
// Directed bench for the accumulator slave: reset, sequential/back-to-back writes,
// wrap-around, simultaneous read+write and asynchronous mid-run reset.
module tb_acumulador_accumulator_slave;
  localparam int DW = 32;

  logic          clock;
  logic          reset_n;
  logic [DW-1:0] sum_export;
  int            checks;
  int            errors;

  acumulador_accumulator_slave_if #(.DATA_WIDTH(DW)) bus ();

  acumulador_accumulator_slave #(.DATA_WIDTH(DW)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .avs        (bus.slave),
    .sum_export (sum_export)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance to just after the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    bus.write = 1'b0;
    bus.read = 1'b0;
    bus.writedata = '0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic write_once(input logic [DW-1:0] d);
    bus.write = 1'b1;
    bus.writedata = d;
    tick();
    bus.write = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.write = 1'b0;
    bus.read = 1'b0;
    bus.writedata = '0;
    #100;
    checks++;
    if (sum_export !== 32'd0) begin
      errors++; $display("FAIL reset_sum_export: got %h expected %h", sum_export, 32'd0);
    end
    checks++;
    if (bus.readdata !== 32'd0) begin
      errors++; $display("FAIL reset_readdata_idle: got %h expected %h", bus.readdata, 32'd0);
    end
    bus.read = 1'b1;
    bus.write = 1'b1;
    bus.writedata = 32'd7;
    tick();
    tick();
    checks++;
    if (sum_export !== 32'd0) begin
      errors++; $display("FAIL reset_write_ignored: got %h expected %h", sum_export, 32'd0);
    end
    checks++;
    if (bus.readdata !== 32'd0) begin
      errors++; $display("FAIL reset_readdata_read: got %h expected %h", bus.readdata, 32'd0);
    end
    bus.write = 1'b0;
    bus.read = 1'b0;
    bus.writedata = '0;
    reset_n = 1'b1;
    tick();
    checks++;
    if (sum_export !== 32'd0) begin
      errors++; $display("FAIL reset_release: got %h expected %h", sum_export, 32'd0);
    end
  endtask

  task automatic test_sequential();
    int exp_sum;
    exp_sum = 0;
    for (int i = 0; i < 10; i++) begin
      write_once(i[DW-1:0]);
      exp_sum += i;
      checks++;
      if (sum_export !== exp_sum[DW-1:0]) begin
        errors++; $display("FAIL seq_step%0d: got %0d expected %0d", i, sum_export, exp_sum);
      end
      tick();
      checks++;
      if (sum_export !== exp_sum[DW-1:0]) begin
        errors++; $display("FAIL seq_hold%0d: got %0d expected %0d", i, sum_export, exp_sum);
      end
    end
    bus.read = 1'b1;
    #1;
    checks++;
    if (bus.readdata !== 32'd45) begin
      errors++; $display("FAIL seq_readdata: got %0d expected %0d", bus.readdata, 45);
    end
    tick();
    checks++;
    if (bus.readdata !== 32'd45) begin
      errors++; $display("FAIL seq_read_no_side_effect: got %0d expected %0d", bus.readdata, 45);
    end
    bus.read = 1'b0;
  endtask

  task automatic test_async_reset();
    // Entered with sum=45; drop reset between edges and look before the next edge.
    #2;
    bus.read = 1'b1;
    reset_n = 1'b0;
    #1;
    checks++;
    if (sum_export !== 32'd0) begin
      errors++; $display("FAIL async_reset_sum: got %0d expected %0d", sum_export, 0);
    end
    checks++;
    if (bus.readdata !== 32'd0) begin
      errors++; $display("FAIL async_reset_readdata: got %0d expected %0d", bus.readdata, 0);
    end
    bus.read = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    write_once(32'd3);
    checks++;
    if (sum_export !== 32'd3) begin
      errors++; $display("FAIL async_reset_after_write: got %0d expected %0d", sum_export, 3);
    end
  endtask

  task automatic test_back_to_back();
    // Entered with sum=3.
    bus.write = 1'b1;
    bus.writedata = 32'd5;
    tick();
    checks++;
    if (sum_export !== 32'd8) begin
      errors++; $display("FAIL b2b_first: got %0d expected %0d", sum_export, 8);
    end
    tick();
    tick();
    bus.write = 1'b0;
    checks++;
    if (sum_export !== 32'd18) begin
      errors++; $display("FAIL b2b_total: got %0d expected %0d", sum_export, 18);
    end
    bus.read = 1'b0;
    tick();
    checks++;
    if (bus.readdata !== 32'd0) begin
      errors++; $display("FAIL b2b_readdata_idle: got %0d expected %0d", bus.readdata, 0);
    end
    checks++;
    if (sum_export !== 32'd18) begin
      errors++; $display("FAIL b2b_export_hold: got %0d expected %0d", sum_export, 18);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    write_once(32'hFFFF_FFFF);
    checks++;
    if (sum_export !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL wrap_max: got %h expected %h", sum_export, 32'hFFFF_FFFF);
    end
    write_once(32'd2);
    checks++;
    if (sum_export !== 32'h0000_0001) begin
      errors++; $display("FAIL wrap_result: got %h expected %h", sum_export, 32'h0000_0001);
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    write_once(32'd10);
    bus.read = 1'b1;
    bus.write = 1'b1;
    bus.writedata = 32'd4;
    #1;
    checks++;
    if (bus.readdata !== 32'd10) begin
      errors++; $display("FAIL simul_pre_edge: got %0d expected %0d", bus.readdata, 10);
    end
    tick();
    bus.write = 1'b0;
    #1;
    checks++;
    if (bus.readdata !== 32'd14) begin
      errors++; $display("FAIL simul_post_edge: got %0d expected %0d", bus.readdata, 14);
    end
    checks++;
    if (sum_export !== 32'd14) begin
      errors++; $display("FAIL simul_export: got %0d expected %0d", sum_export, 14);
    end
    bus.read = 1'b0;
    write_once(32'd0);
    checks++;
    if (sum_export !== 32'd14) begin
      errors++; $display("FAIL zero_write: got %0d expected %0d", sum_export, 14);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_sequential();
    test_async_reset();
    test_back_to_back();
    test_wrap();
    test_simultaneous();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
